// File: rtl/sc_pkg.sv
// Shared encodings and helpers for the stochastic-computing PE datapath.
package sc_pkg;

  localparam logic SC_UNIPOLAR = 1'b0;
  localparam logic SC_BIPOLAR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_e;

  // Reverses the low n bits of v; bits at or above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        if (i < n && j == n - 1 - i) r[i] = v[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational ones count over a LANES-wide chunk of stream bits.
module sc_popcount #(
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES) + 1
) (
  input  logic [LANES-1:0] bits,
  output logic [CW-1:0]    cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/sc_mult_seq.sv
// Sequential SC multiplier: exact ones count over the full 2^(2N) stream, LANES bits/clock.
// Result appears CYCLES clocks after accept and is held in DONE until out_ready.
module sc_mult_seq
  import sc_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_WIDTH:0] c
);

  localparam int N         = DATA_WIDTH;
  localparam int KW        = 2 * N;
  localparam int OUT_WIDTH = 2 * N + 1;
  localparam int CYCLES    = (2 ** KW) / LANES;
  localparam int PW        = $clog2(LANES) + 1;
  localparam logic [KW-1:0] LAST_K = KW'((CYCLES - 1) * LANES);

  sc_state_e              state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   c_q, c_d;
  logic [N-1:0]           a_q, a_d, b_q, b_d;
  logic                   mode_q, mode_d;
  logic [LANES-1:0]       bits;
  logic [PW-1:0]          cnt;
  logic [OUT_WIDTH-1:0]   acc_sum;

  // Lane j evaluates stream position k + j: a against the bit-reversed low half,
  // b against the high half (a ramp that steps once per 2^N positions).
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [KW-1:0] idx;
    logic          sa, sb;
    assign idx     = k_q + KW'(j);
    assign sa      = a_q > N'(bitrev(32'(idx[N-1:0]), N));
    assign sb      = b_q > idx[KW-1:N];
    assign bits[j] = (mode_q == SC_UNIPOLAR) ? (sa & sb) : ~(sa ^ sb);
  end

  sc_popcount #(.LANES(LANES)) u_popcount (
    .bits (bits),
    .cnt  (cnt)
  );

  assign acc_sum = acc_q + OUT_WIDTH'(cnt);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode ? SC_BIPOLAR : SC_UNIPOLAR;
          k_d     = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        k_d   = k_q + KW'(LANES);
        if (k_q == LAST_K) begin
          c_d     = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= SC_UNIPOLAR;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;

endmodule

// File: doc/sc_mult_seq.md
Name: sc_mult_seq

Overview:
- Sequential, parametrised stochastic-computing multiplier. It is the successor to the fixed 32-bit combinational Sobol-comparator multiplier.
- Generates both comparator bitstreams internally from one 2N-bit sequence counter:
  - operand a is compared against a bit-reversed (van der Corput / Sobol dim-1) sequence;
  - operand b is compared against a linear ramp.
- Evaluates LANES stream bits per clock and accumulates the ones count over the full 2^(2N) stream, so the product is exact.
- Supports unipolar (AND) and bipolar (XNOR) modes. Sits in the SC PE datapath behind a valid/ready handshake.

Parameters:
- DATA_WIDTH, 4, operand width N; stream length L2 = 2^(2N).
- LANES, 4, stream bits evaluated per clock; power of two, 1 <= LANES <= 2^N.
- CYCLES (localparam), 2^(2N)/LANES, RUN duration in clocks.
- OUT_WIDTH (localparam), 2N+1, count width (holds up to 2^(2N)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  DATA_WIDTH  operand a, unsigned.
- b  in  DATA_WIDTH  operand b, unsigned.
- mode  in  1  0 = unipolar AND, 1 = bipolar XNOR; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- c  out  OUT_WIDTH  ones count of the product stream.

Behaviour:
- Reset values, applied immediately while rst is high:
  - state = IDLE, in_ready = 1, out_valid = 0, c = 0;
  - sequence counter k = 0, accumulator = 0, latched a/b/mode = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch a, b, mode; k = 0; acc = 0; go to RUN.
  - RUN: in_ready = 0. Each edge, for lane j in 0..LANES-1, with idx = k + j:
    - lo = idx[N-1:0], hi = idx[2N-1:N];
    - sa = (a > bitrev_N(lo)); sb = (b > hi);
    - bit_j = mode ? ~(sa ^ sb) : (sa & sb).
    - acc += popcount(bits); k += LANES.
    - On the edge consuming the last chunk (k == 2^(2N) - LANES), go to DONE with the final acc loaded into c.
  - DONE: out_valid = 1; c holds stable. On out_ready go to IDLE; out_valid drops on that edge.
- Latency: out_valid rises exactly CYCLES edges after the accepting edge. The result is held indefinitely under backpressure.
- Result arithmetic, with L = 2^N:
  - unipolar: c = a*b exactly;
  - bipolar: c = a*b + (L-a)*(L-b).
- Width rules:
  - k is 2N bits and wraps to 0 after the last chunk; it is never read outside RUN.
  - acc is OUT_WIDTH bits and cannot overflow.
- Boundary cases:
  - a = 0 or b = 0 in unipolar gives c = 0.
  - in_valid during RUN or DONE is ignored and not latched (in_ready = 0).
  - Input changes after accept have no effect.
  - rst mid-RUN or mid-DONE aborts the operation: outputs return to reset values and the result is discarded.
  - out_ready while out_valid = 0 has no effect.
  - There is no back-to-back accept in the DONE→IDLE cycle; in_ready reasserts the cycle after the result handoff.

Decomposition:
- Shared package sc_pkg:
  - mode encodings SC_UNIPOLAR = 0, SC_BIPOLAR = 1;
  - state encodings IDLE/RUN/DONE;
  - a bit-reverse function.
- One sub-module: sc_popcount, parametrised by LANES, purely combinational, output width clog2(LANES)+1.
- The lane comparator array stays inline in sc_mult_seq.

Test Plan (DATA_WIDTH = 4, LANES = 4 unless noted, CYCLES = 64):
1. Unipolar a=15, b=15 → c=225; out_valid rises exactly 64 clocks after accept; in_ready = 0 throughout.
2. Unipolar a=0, b=9 → c=0; and a=7, b=5 → c=35.
3. Bipolar a=8, b=8 → c=128; bipolar a=15, b=0 → c=16; bipolar a=0, b=0 → c=256 (needs bit 8).
4. Backpressure: out_ready held low 20 clocks after out_valid → c and out_valid stable; in_valid pulses during RUN/DONE are ignored; out_ready=1 → IDLE next clock.
5. Assert rst at RUN clock 30 → out_valid = 0, c = 0 immediately. A new a=3, b=3 transaction then yields 9.
6. Sweep all 256 (a,b) pairs in both modes with LANES ∈ {1, 4, 16} → all results match the formulas; CYCLES = 256, 64, 16 respectively.
